// File: rtl/big_core_cr_bank.sv
// Memory-mapped control-register bank: seven-segment/LED outputs, button/switch/joystick inputs, keyboard scan FIFO.
// Optional macro BIG_CORE_CR_DEBOUNCE_EN adds a per-bit debounce filter after the button/switch synchroniser.
module big_core_cr_bank #(
    parameter int NUM_SEG7       = 6,
    parameter int LED_W          = 10,
    parameter int SW_W           = 10,
    parameter int JOY_W          = 12,
    parameter int KBD_FIFO_DEPTH = 8,
    parameter int DBNC_CYCLES    = 16
) (
    input  logic                  Clk,
    input  logic                  RstN,
    input  logic [31:0]           Address,
    input  logic [31:0]           WrData,
    input  logic                  WrEn,
    input  logic                  RdEn,
    input  logic [3:0]            ByteEn,
    output logic [31:0]           RdData,
    input  logic                  Button_0,
    input  logic                  Button_1,
    input  logic [SW_W-1:0]       Switch,
    input  logic [JOY_W-1:0]      Joystick_x,
    input  logic [JOY_W-1:0]      Joystick_y,
    input  logic [7:0]            KbdData,
    input  logic                  KbdValid,
    output logic [8*NUM_SEG7-1:0] SEG7,
    output logic [LED_W-1:0]      LED
);

    localparam int IN_W = SW_W + 2;
    localparam int AW   = $clog2(KBD_FIFO_DEPTH);
    localparam int CW   = AW + 1;

    localparam logic [15:0] OFF_LED      = 16'h0040;
    localparam logic [15:0] OFF_BUTTON   = 16'h0044;
    localparam logic [15:0] OFF_SWITCH   = 16'h0048;
    localparam logic [15:0] OFF_JOY_X    = 16'h004C;
    localparam logic [15:0] OFF_JOY_Y    = 16'h0050;
    localparam logic [15:0] OFF_KBD_DATA = 16'h0100;
    localparam logic [15:0] OFF_KBD_STAT = 16'h0104;
    localparam logic [15:0] OFF_KBD_CTRL = 16'h0108;

    function automatic logic [31:0] laneMerge(input logic [31:0] oldVal,
                                              input logic [31:0] newVal,
                                              input logic [3:0]  be);
        logic [31:0] r;
        r = oldVal;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[8*k +: 8] = newVal[8*k +: 8];
        end
        return r;
    endfunction

    logic        hit;
    logic [15:0] offset;
    logic        wrHit;
    logic        rdHit;
    logic        unusedAddr;

    assign hit        = (Address[23:16] == 8'hFE);
    assign offset     = Address[15:0];
    assign wrHit      = WrEn && hit;
    assign rdHit      = RdEn && hit;
    assign unusedAddr = ^Address[31:24];

    logic [7:0]       seg7Reg [NUM_SEG7];
    logic [LED_W-1:0] ledReg;
    logic             scanfEn;
    logic             overflow;

    logic [7:0]    fifoMem [KBD_FIFO_DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic          notEmpty;
    logic          full;
    logic          ctrlWr;
    logic          flush;
    logic          pushReq;
    logic          doPush;
    logic          doPop;
    logic          dropPush;

    assign notEmpty = (count != '0);
    assign full     = (count == CW'(KBD_FIFO_DEPTH));
    assign ctrlWr   = wrHit && (offset == OFF_KBD_CTRL) && ByteEn[0];
    assign flush    = ctrlWr && scanfEn && !WrData[0];
    assign pushReq  = KbdValid && scanfEn;
    // A full FIFO still accepts a push when a pop frees the head slot on the same edge.
    assign doPop    = rdHit && (offset == OFF_KBD_DATA) && notEmpty;
    assign doPush   = pushReq && (!full || doPop);
    assign dropPush = pushReq && full && !doPop;

    // Input stage: two-flop synchroniser for buttons/switches, single register for joystick
    logic [IN_W-1:0]  inSync_p0;
    logic [IN_W-1:0]  inSync_p1;
    logic [IN_W-1:0]  inArch;
    logic [JOY_W-1:0] joyX_p0;
    logic [JOY_W-1:0] joyY_p0;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            inSync_p0 <= '0;
            inSync_p1 <= '0;
        end else begin
            inSync_p0 <= {Switch, Button_1, Button_0};
            inSync_p1 <= inSync_p0;
        end
    end

    always_ff @(posedge Clk) begin
        joyX_p0 <= Joystick_x;
        joyY_p0 <= Joystick_y;
    end

`ifdef BIG_CORE_CR_DEBOUNCE_EN
    // Debounce stage: a bit adopts the synchronised value after DBNC_CYCLES consecutive differing samples
    logic [15:0]     dbncCnt [IN_W];
    logic [IN_W-1:0] dbncVal;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            dbncVal <= '0;
            for (int b = 0; b < IN_W; b++) dbncCnt[b] <= '0;
        end else begin
            for (int b = 0; b < IN_W; b++) begin
                if (inSync_p1[b] == dbncVal[b]) begin
                    dbncCnt[b] <= '0;
                end else if (dbncCnt[b] == 16'(DBNC_CYCLES - 1)) begin
                    dbncVal[b] <= inSync_p1[b];
                    dbncCnt[b] <= '0;
                end else begin
                    dbncCnt[b] <= dbncCnt[b] + 16'd1;
                end
            end
        end
    end

    assign inArch = dbncVal;
`else
    assign inArch = inSync_p1;
`endif

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            for (int i = 0; i < NUM_SEG7; i++) seg7Reg[i] <= '0;
            ledReg  <= '0;
            scanfEn <= 1'b0;
        end else begin
            if (wrHit && ByteEn[0]) begin
                for (int i = 0; i < NUM_SEG7; i++) begin
                    if (offset == 16'(4 * i)) seg7Reg[i] <= WrData[7:0];
                end
            end
            if (wrHit && (offset == OFF_LED))
                ledReg <= LED_W'(laneMerge(32'(ledReg), WrData, ByteEn));
            if (ctrlWr)
                scanfEn <= WrData[0];
        end
    end

    // Overflow is sticky; a drop in the same cycle as a clear wins so the event is not lost.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            overflow <= 1'b0;
        end else if (dropPush) begin
            overflow <= 1'b1;
        end else if (ctrlWr && WrData[1]) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end

    always_ff @(posedge Clk) begin
        if (doPush && !flush) fifoMem[wrPtr] <= KbdData;
    end

    logic [31:0] rdMux;

    always_comb begin
        rdMux = '0;
        if (hit) begin
            for (int i = 0; i < NUM_SEG7; i++) begin
                if (offset == 16'(4 * i)) rdMux = {24'b0, seg7Reg[i]};
            end
            case (offset)
                OFF_LED:      rdMux = 32'(ledReg);
                OFF_BUTTON:   rdMux = {30'b0, inArch[1:0]};
                OFF_SWITCH:   rdMux = 32'(inArch[IN_W-1:2]);
                OFF_JOY_X:    rdMux = 32'(joyX_p0);
                OFF_JOY_Y:    rdMux = 32'(joyY_p0);
                OFF_KBD_DATA: rdMux = notEmpty ? {24'b0, fifoMem[rdPtr]} : 32'b0;
                OFF_KBD_STAT: rdMux = {17'b0, 7'(count), 5'b0, overflow, full, notEmpty};
                OFF_KBD_CTRL: rdMux = {31'b0, scanfEn};
                default:      ;
            endcase
        end
    end

    // Read response stage: captured on RdEn, held until the next read
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            RdData <= '0;
        end else if (RdEn) begin
            RdData <= rdMux;
        end
    end

    for (genvar g = 0; g < NUM_SEG7; g++) begin : gSeg7
        assign SEG7[8*g +: 8] = seg7Reg[g];
    end

    assign LED = ledReg;

endmodule

// File: tb/tb_big_core_cr_bank.sv
// Directed bench for big_core_cr_bank: register access, byte lanes, input paths, keyboard FIFO, reset.
module tb_big_core_cr_bank;

    localparam int NUM_SEG7 = 6;
    localparam int LED_W    = 10;
    localparam int SW_W     = 10;
    localparam int JOY_W    = 12;

    localparam logic [31:0] A_SEG0 = 32'h00FE0000;
    localparam logic [31:0] A_SEG2 = 32'h00FE0008;
    localparam logic [31:0] A_LED  = 32'h00FE0040;
    localparam logic [31:0] A_BTN  = 32'h00FE0044;
    localparam logic [31:0] A_SW   = 32'h00FE0048;
    localparam logic [31:0] A_JX   = 32'h00FE004C;
    localparam logic [31:0] A_JY   = 32'h00FE0050;
    localparam logic [31:0] A_KDAT = 32'h00FE0100;
    localparam logic [31:0] A_KSTA = 32'h00FE0104;
    localparam logic [31:0] A_KCTL = 32'h00FE0108;

`ifdef BIG_CORE_CR_DEBOUNCE_EN
    localparam int SETTLE = 25;
`else
    localparam int SETTLE = 4;
`endif

    logic                  Clk = 1'b0;
    logic                  RstN = 1'b0;
    logic [31:0]           Address = '0;
    logic [31:0]           WrData = '0;
    logic                  WrEn = 1'b0;
    logic                  RdEn = 1'b0;
    logic [3:0]            ByteEn = '0;
    logic [31:0]           RdData;
    logic                  Button_0 = 1'b0;
    logic                  Button_1 = 1'b0;
    logic [SW_W-1:0]       Switch = '0;
    logic [JOY_W-1:0]      Joystick_x = '0;
    logic [JOY_W-1:0]      Joystick_y = '0;
    logic [7:0]            KbdData = '0;
    logic                  KbdValid = 1'b0;
    logic [8*NUM_SEG7-1:0] SEG7;
    logic [LED_W-1:0]      LED;

    int nCompared   = 0;
    int nMismatched = 0;

    big_core_cr_bank #(
        .NUM_SEG7(NUM_SEG7), .LED_W(LED_W), .SW_W(SW_W), .JOY_W(JOY_W),
        .KBD_FIFO_DEPTH(8), .DBNC_CYCLES(16)
    ) dut (
        .Clk(Clk), .RstN(RstN), .Address(Address), .WrData(WrData), .WrEn(WrEn),
        .RdEn(RdEn), .ByteEn(ByteEn), .RdData(RdData), .Button_0(Button_0),
        .Button_1(Button_1), .Switch(Switch), .Joystick_x(Joystick_x),
        .Joystick_y(Joystick_y), .KbdData(KbdData), .KbdValid(KbdValid),
        .SEG7(SEG7), .LED(LED)
    );

    always #5 Clk = ~Clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        Address = a; WrData = d; ByteEn = be; WrEn = 1'b1;
        @(posedge Clk);
        #1;
        WrEn = 1'b0; ByteEn = '0;
    endtask

    task automatic busRead(input logic [31:0] a, output logic [31:0] d);
        Address = a; RdEn = 1'b1;
        @(posedge Clk);
        #1;
        RdEn = 1'b0;
        d = RdData;
    endtask

    task automatic kbdPush(input logic [7:0] b);
        KbdData = b; KbdValid = 1'b1;
        @(posedge Clk);
        #1;
        KbdValid = 1'b0;
    endtask

    task automatic pushPop(input logic [7:0] b, output logic [31:0] d);
        KbdData = b; KbdValid = 1'b1; Address = A_KDAT; RdEn = 1'b1;
        @(posedge Clk);
        #1;
        KbdValid = 1'b0; RdEn = 1'b0;
        d = RdData;
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  expB;

        #3;
        checkEq("rst_led", 32'(LED), 32'h0);
        checkEq("rst_seg7", 32'(SEG7[31:0]), 32'h0);
        checkEq("rst_rddata", RdData, 32'h0);
        idle(2);
        RstN = 1'b1;
        idle(1);

        busWrite(A_SEG2, 32'h000000A5, 4'b0001);
        checkEq("seg7_digit2", {24'b0, SEG7[23:16]}, 32'hA5);
        busRead(A_SEG2, d);
        checkEq("seg7_2_read", d, 32'hA5);
        busWrite(A_SEG0, 32'hFFFFFFFF, 4'b0010);
        checkEq("seg7_0_lane_off", {24'b0, SEG7[7:0]}, 32'h0);
        busWrite(A_LED, 32'h12345678, 4'b0011);
        checkEq("led_trunc", 32'(LED), 32'h278);
        busRead(A_LED, d);
        checkEq("led_read", d, 32'h278);
        idle(3);
        checkEq("rddata_hold", RdData, 32'h278);
        busWrite(32'h00FD0040, 32'h0, 4'b1111);
        checkEq("nonhit_write", 32'(LED), 32'h278);
        busRead(32'h00FD0008, d);
        checkEq("nonhit_read", d, 32'h0);
        busRead(32'h00FE0060, d);
        checkEq("unmapped_read", d, 32'h0);
        busWrite(A_BTN, 32'hFFFFFFFF, 4'b1111);
        busRead(A_BTN, d);
        checkEq("ro_write_ignored", d, 32'h0);

        Switch = 10'h2A5; Button_0 = 1'b1;
        Joystick_x = 12'hABC; Joystick_y = 12'h123;
        idle(SETTLE);
        busRead(A_SW, d);
        checkEq("switch", d, 32'h2A5);
        busRead(A_BTN, d);
        checkEq("button0", d, 32'h1);
        busRead(A_JX, d);
        checkEq("joy_x", d, 32'hABC);
        busRead(A_JY, d);
        checkEq("joy_y", d, 32'h123);
        Button_1 = 1'b1;
`ifndef BIG_CORE_CR_DEBOUNCE_EN
        busRead(A_BTN, d);
        checkEq("sync_lat1", d, 32'h1);
        busRead(A_BTN, d);
        checkEq("sync_lat2", d, 32'h1);
`else
        idle(SETTLE);
`endif
        busRead(A_BTN, d);
        checkEq("button_both", d, 32'h3);
        Button_0 = 1'b0; Button_1 = 1'b0;

        kbdPush(8'h55);
        busRead(A_KSTA, d);
        checkEq("push_disabled", d, 32'h0);
        busWrite(A_KCTL, 32'h1, 4'b0001);
        busRead(A_KCTL, d);
        checkEq("ctrl_read", d, 32'h1);
        kbdPush(8'h1C); kbdPush(8'h32); kbdPush(8'h21);
        busRead(A_KSTA, d);
        checkEq("status_cnt3", d, 32'h0301);
        busRead(A_KDAT, d);
        checkEq("kbd_pop0", d, 32'h1C);
        busRead(A_KDAT, d);
        checkEq("kbd_pop1", d, 32'h32);
        busRead(A_KDAT, d);
        checkEq("kbd_pop2", d, 32'h21);
        busRead(A_KDAT, d);
        checkEq("kbd_pop_empty", d, 32'h0);
        busRead(A_KSTA, d);
        checkEq("status_empty", d, 32'h0);

        for (int i = 0; i < 9; i++) kbdPush(8'h10 + 8'(i));
        busRead(A_KSTA, d);
        checkEq("status_full_ovf", d, 32'h0807);
        pushPop(8'h19, d);
        checkEq("full_pushpop_data", d, 32'h10);
        busRead(A_KSTA, d);
        checkEq("full_pushpop_cnt", d, 32'h0807);
        for (int i = 0; i < 8; i++) begin
            expB = (i < 7) ? 8'h11 + 8'(i) : 8'h19;
            busRead(A_KDAT, d);
            checkEq($sformatf("drain_%0d", i), d, {24'b0, expB});
        end
        busRead(A_KSTA, d);
        checkEq("status_ovf_only", d, 32'h0004);
        busWrite(A_KCTL, 32'h1, 4'b0001);
        kbdPush(8'hAA); kbdPush(8'hBB);
        busWrite(A_KCTL, 32'h0, 4'b0001);
        busRead(A_KSTA, d);
        checkEq("flush_keeps_ovf", d, 32'h0004);
        busWrite(A_KCTL, 32'h2, 4'b0001);
        busRead(A_KSTA, d);
        checkEq("ovf_cleared", d, 32'h0);
        busRead(A_KCTL, d);
        checkEq("ctrl_after_clr", d, 32'h0);

        busWrite(A_KCTL, 32'h1, 4'b0001);
        pushPop(8'h77, d);
        checkEq("empty_no_bypass", d, 32'h0);
        busRead(A_KSTA, d);
        checkEq("empty_pushpop_cnt", d, 32'h0101);
        busRead(A_KDAT, d);
        checkEq("empty_pushpop_data", d, 32'h77);

        Address = A_LED; WrData = 32'h155; ByteEn = 4'b1111; WrEn = 1'b1; RdEn = 1'b1;
        @(posedge Clk);
        #1;
        WrEn = 1'b0; RdEn = 1'b0; ByteEn = '0;
        checkEq("wr_rd_old_data", RdData, 32'h278);
        checkEq("wr_rd_led", 32'(LED), 32'h155);

        busWrite(A_LED, 32'h3FF, 4'b0011);
        kbdPush(8'h01); kbdPush(8'h02);
        busRead(A_LED, d);
        checkEq("led_3ff", d, 32'h3FF);
        Address = A_LED; RdEn = 1'b1;
        #2;
        RstN = 1'b0;
        #1;
        checkEq("midrst_led", 32'(LED), 32'h0);
        checkEq("midrst_rddata", RdData, 32'h0);
        checkEq("midrst_seg7", {24'b0, SEG7[23:16]}, 32'h0);
        @(posedge Clk);
        #1;
        RdEn = 1'b0;
        checkEq("rst_held_rddata", RdData, 32'h0);
        RstN = 1'b1;
        idle(1);
        busRead(A_LED, d);
        checkEq("post_rst_led", d, 32'h0);
        busRead(A_KSTA, d);
        checkEq("post_rst_fifo", d, 32'h0);
        busRead(A_KCTL, d);
        checkEq("post_rst_ctrl", d, 32'h0);

`ifdef BIG_CORE_CR_DEBOUNCE_EN
        idle(SETTLE);
        Button_0 = 1'b1;
        idle(5);
        Button_0 = 1'b0;
        idle(SETTLE);
        busRead(A_BTN, d);
        checkEq("dbnc_glitch", d & 32'h1, 32'h0);
        Button_0 = 1'b1;
        idle(14);
        busRead(A_BTN, d);
        checkEq("dbnc_early", d & 32'h1, 32'h0);
        idle(5);
        busRead(A_BTN, d);
        checkEq("dbnc_pulse", d & 32'h1, 32'h1);
        Button_0 = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
